// File: rtl/series_ctrl_p.sv
// Control FSM for the series-evaluation datapath.
// Loads x, runs NTERMS multiply/accumulate rounds, then pulses done.
module series_ctrl_p #(
    parameter int NTERMS     = 4,
    parameter int MULT_STEPS = 4,
    parameter int X_STEPS    = 2,
    parameter int ROM_AW     = 4,
    parameter int TW         = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              alt,
    input  logic              abort,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              ldx,
    output logic              initt,
    output logic              initr,
    output logic              ldt,
    output logic              sel_rom,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              ldr,
    output logic              add_sub,
    output logic [TW-1:0]     term_idx
);

    localparam int SW = (MULT_STEPS > 1) ? $clog2(MULT_STEPS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        LOAD,
        MULT,
        ACC,
        DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [SW-1:0] s;
    logic          alt_q;
    logic          last_step;
    logic          last_term;
    logic          rom_step;

    assign last_step = (s == SW'(MULT_STEPS - 1));
    assign last_term = (term_idx == TW'(NTERMS - 1));
    assign rom_step  = (state == MULT) && (int'(s) >= X_STEPS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Counters freeze on abort so the aborted position stays visible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s        <= '0;
            term_idx <= '0;
            rom_addr <= '0;
            alt_q    <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    s        <= '0;
                    term_idx <= '0;
                    rom_addr <= '0;
                    if (!start && !abort) begin
                        alt_q <= alt;
                    end
                end
                MULT: begin
                    if (!abort) begin
                        s <= last_step ? '0 : s + SW'(1);
                        if (rom_step) begin
                            rom_addr <= rom_addr + ROM_AW'(1);
                        end
                    end
                end
                ACC: begin
                    if (!abort && !last_term) begin
                        term_idx <= term_idx + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = INIT;
            INIT: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (!start) begin
                    state_n = LOAD;
                end
            end
            LOAD: state_n = abort ? IDLE : MULT;
            MULT: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (last_step) begin
                    state_n = ACC;
                end
            end
            ACC: begin
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    state_n = last_term ? DONE : MULT;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ready   = (state == IDLE);
        busy    = 1'b0;
        done    = 1'b0;
        ldx     = 1'b0;
        initt   = 1'b0;
        initr   = 1'b0;
        ldt     = 1'b0;
        ldr     = 1'b0;
        sel_rom = rom_step;
        add_sub = ~(alt_q & term_idx[0]);
        case (state)
            INIT: begin
                busy  = 1'b1;
                initt = 1'b1;
                initr = 1'b1;
            end
            LOAD: begin
                busy = 1'b1;
                ldx  = 1'b1;
            end
            MULT: begin
                busy = 1'b1;
                ldt  = 1'b1;
            end
            ACC: begin
                busy = 1'b1;
                ldr  = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/series_ctrl_p.md
# series_ctrl_p

Parametrised control FSM for the series-evaluation accelerator datapath: x register, term register t, result register r, coefficient ROM and adder/subtractor. Per run it:

- loads x once;
- for each of NTERMS terms, runs MULT_STEPS multiply cycles (x operand first, then ROM operand), then accumulates the term into r with a selectable sign pattern;
- finishes with a one-cycle done pulse.

It replaces the fixed four-multiply, externally-terminated controller. It has an internal term counter, a generated ROM address, an abort, and a constant- or alternating-sign mode.

## Interface
Parameters:
- NTERMS, 4, terms accumulated per run (≥1)
- MULT_STEPS, 4, ldt cycles per term (≥1)
- X_STEPS, 2, leading multiply steps using x (0..MULT_STEPS); the rest use the ROM
- ROM_AW, 4, ROM address width; wraps mod 2^ROM_AW
- TW, 3, term index width; must hold NTERMS-1

Ports (reset: asynchronous, active-high; clock: clock):
- clock  in  1  system clock, rising edge
- reset  in  1  async active-high reset
- start  in  1  level; run begins when start falls while in INIT
- alt  in  1  sign mode, sampled on INIT→LOAD: 1 = alternate +,−,+,…; 0 = all add
- abort  in  1  synchronous abort, any non-IDLE state
- ready  out  1  high only in IDLE
- busy  out  1  high in INIT..ACC
- done  out  1  one-cycle pulse in DONE state
- ldx  out  1  load x register
- initt  out  1  set t to 1
- initr  out  1  clear r
- ldt  out  1  load t ← t × operand
- sel_rom  out  1  0 = x operand, 1 = ROM operand
- rom_addr  out  ROM_AW  coefficient ROM address (registered counter)
- ldr  out  1  load r ← r ± t
- add_sub  out  1  1 = add, 0 = subtract
- term_idx  out  TW  current term number (registered)

## Operation
States: IDLE, INIT, LOAD, MULT, ACC, DONE. The state register and counters (step s, term_idx, rom_addr, alt_q) are reset to IDLE/0. All strobes are decoded combinationally from the state and counters.

- **IDLE**
  - ready=1.
  - start=1 → INIT.
- **INIT**
  - initt=initr=1; s, term_idx, rom_addr ← 0.
  - Stays in INIT while start=1.
  - start=0 → LOAD; alt_q ← alt.
- **LOAD**
  - ldx=1 for one cycle → MULT.
- **MULT**
  - ldt=1 every cycle; sel_rom = (s ≥ X_STEPS).
  - rom_addr increments after each cycle with sel_rom=1.
  - s increments; at s = MULT_STEPS-1 → ACC with s ← 0.
- **ACC**
  - ldr=1 for one cycle.
  - add_sub = ~(alt_q & term_idx[0]).
  - term_idx = NTERMS-1 → DONE; otherwise term_idx+1 → MULT.
  - t is not reinitialised between terms: each term is the previous t × x^X_STEPS × ROM coefficients.
- **DONE**
  - done=1 → IDLE.
- **add_sub outside ACC**: follows the same formula; it is 1 at reset.
- **abort=1** in INIT, LOAD, MULT, ACC or DONE:
  - next state IDLE, no done pulse, no strobe issued in the following cycle;
  - counters keep their values until the next INIT.
  - abort in IDLE is ignored.
- **abort and a start edge in the same cycle**: abort wins.
- **start re-asserted mid-run**: ignored until the FSM returns to IDLE.
- **reset mid-run**: immediately IDLE; all outputs take reset values (ready=1, everything else 0, add_sub=1).

## Timing
- Let cycle 0 be the first LOAD cycle.
- Term k (0-based) occupies:
  - MULT cycles 1+k·(MULT_STEPS+1) through k·(MULT_STEPS+1)+MULT_STEPS;
  - its ACC cycle, (k+1)·(MULT_STEPS+1).
- DONE is at cycle 1+NTERMS·(MULT_STEPS+1); with the defaults this is cycle 21, and ready rises at cycle 22.
- rom_addr during the j-th ROM step of term k is k·(MULT_STEPS−X_STEPS)+j.
- With X_STEPS=MULT_STEPS, sel_rom is never 1 and rom_addr stays 0.
- With X_STEPS=0, all steps use the ROM.
- NTERMS=1 gives a single ACC followed by DONE.

## Test plan
All scenarios use the default parameters unless stated.

- **Basic run, alternating**: reset, then start 1 for 3 cycles, then 0, with alt=1.
  - INIT lasts 3 cycles; ldx at cycle 0; ldt high for 4 cycles per term; sel_rom pattern 0,0,1,1.
  - ldr at cycles 5, 10, 15, 20 with add_sub 1,0,1,0.
  - done at 21, ready at 22.
  - rom_addr at the sel_rom=1 cycles: 0,1 | 2,3 | 4,5 | 6,7.
- **Constant sign**: alt=0 → all four ldr cycles have add_sub=1.
  - Changing alt after cycle 0 has no effect.
- **Abort**: abort pulsed at cycle 7 (term 1 MULT) → IDLE at cycle 8, ready=1, done never asserted, no ldr at 10.
  - A fresh start afterwards runs a full 21-cycle sequence from rom_addr 0.
- **Reset mid-run**: reset asserted at cycle 12 between clock edges → ready=1 and all strobes 0 immediately, with no clock edge needed.
- **Parameter corners**:
  - NTERMS=1, MULT_STEPS=1, X_STEPS=0: LOAD, MULT (sel_rom=1, rom_addr 0), ACC, DONE at cycle 3.
  - X_STEPS=MULT_STEPS=3: sel_rom stays 0 and rom_addr stays 0 throughout.
- **Start held / re-asserted**:
  - start held 10 cycles → FSM stays in INIT with initt=initr=1 throughout.
  - start pulsed during MULT → sequence timing unchanged.
